// File: rtl/src_operand_fetch.sv
// src_operand_fetch: resolves the SRC operand of the current instruction
// (IMM, ACC, NIL, directed PORT, ANY, LAST) and presents it, registered, on
// src_data/src_valid for the ALU/ACC stage. A port read blocks in WAIT until
// the neighbour offers a word through a valid/ready handshake.
//
// Optional build macro: SRC_OPERAND_FETCH_SAT_EN
//   defined   : IMM and port-sourced values are clamped to [-999, 999]
//   undefined : every value is passed raw at DATA_W bits
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a source request (req_ready=1)
// WAIT  | blocked on a port read (stall=1), ready driven from valid
// HOLD  | operand registered on src_data, waiting for src_ready
module src_operand_fetch #(
    parameter int DATA_W    = 11,
    parameter int NUM_PORTS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    input  logic [2:0]                  req_sel,
    input  logic [1:0]                  req_dir,
    input  logic [DATA_W-1:0]           req_imm,
    input  logic [DATA_W-1:0]           acc,
    output logic                        req_ready,
    input  logic [NUM_PORTS*DATA_W-1:0] port_in_data,
    input  logic [NUM_PORTS-1:0]        port_in_valid,
    output logic [NUM_PORTS-1:0]        port_in_ready,
    output logic                        src_valid,
    output logic [DATA_W-1:0]           src_data,
    input  logic                        src_ready,
    output logic                        stall,
    output logic                        last_valid,
    output logic [1:0]                  last_dir
);

    localparam logic [2:0] SEL_IMM  = 3'd0;
    localparam logic [2:0] SEL_ACC  = 3'd1;
    localparam logic [2:0] SEL_NIL  = 3'd2;
    localparam logic [2:0] SEL_PORT = 3'd3;
    localparam logic [2:0] SEL_ANY  = 3'd4;
    localparam logic [2:0] SEL_LAST = 3'd5;

`ifdef SRC_OPERAND_FETCH_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(999);
    localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(-999);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          target;
    logic                any_mode;
    logic [1:0]          any_idx;
    logic                any_hit;
    logic [1:0]          hs_idx;
    logic [DATA_W-1:0]   hs_data;
    logic                handshake;

    // Clamp applied to IMM and port-sourced values; a pass-through when disabled.
    function automatic logic [DATA_W-1:0] sat(input logic [DATA_W-1:0] v);
`ifdef SRC_OPERAND_FETCH_SAT_EN
        if ($signed(v) > SAT_HI) return SAT_HI;
        if ($signed(v) < SAT_LO) return SAT_LO;
        return v;
`else
        return v;
`endif
    endfunction

    // ANY arbitration: first valid port in order LEFT, RIGHT, UP, DOWN.
    always_comb begin
        any_hit = 1'b1;
        any_idx = 2'd3;
        if (port_in_valid[3])      any_idx = 2'd3;
        else if (port_in_valid[1]) any_idx = 2'd1;
        else if (port_in_valid[0]) any_idx = 2'd0;
        else if (port_in_valid[2]) any_idx = 2'd2;
        else                       any_hit = 1'b0;
    end

    // Ready toward the neighbours; forced low during reset so no word is lost.
    always_comb begin
        port_in_ready = '0;
        if (!rst && state == ST_WAIT) begin
            if (any_mode) begin
                if (any_hit) port_in_ready[any_idx] = 1'b1;
            end else begin
                port_in_ready[target] = port_in_valid[target];
            end
        end
    end

    assign hs_idx    = any_mode ? any_idx : target;
    assign handshake = |(port_in_ready & port_in_valid);
    assign req_ready = (state == ST_IDLE);
    assign stall     = (state == ST_WAIT);

    // Selects the data word of the port taking part in the handshake.
    always_comb begin
        hs_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (hs_idx == i[1:0]) hs_data = port_in_data[i*DATA_W +: DATA_W];
        end
    end

    // Operand FSM with registered operand and LAST bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            src_valid  <= 1'b0;
            src_data   <= '0;
            last_valid <= 1'b0;
            last_dir   <= 2'd0;
            target     <= 2'd0;
            any_mode   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (req_sel)
                            SEL_IMM: begin
                                src_data  <= sat(req_imm);
                                src_valid <= 1'b1;
                                state     <= ST_HOLD;
                            end
                            SEL_ACC: begin
                                src_data  <= acc;
                                src_valid <= 1'b1;
                                state     <= ST_HOLD;
                            end
                            SEL_PORT: begin
                                target   <= req_dir;
                                any_mode <= 1'b0;
                                state    <= ST_WAIT;
                            end
                            SEL_ANY: begin
                                any_mode <= 1'b1;
                                state    <= ST_WAIT;
                            end
                            SEL_LAST: begin
                                if (last_valid) begin
                                    target   <= last_dir;
                                    any_mode <= 1'b0;
                                    state    <= ST_WAIT;
                                end else begin
                                    src_data  <= '0;
                                    src_valid <= 1'b1;
                                    state     <= ST_HOLD;
                                end
                            end
                            default: begin
                                // NIL and the unused encodings 6/7
                                src_data  <= '0;
                                src_valid <= 1'b1;
                                state     <= ST_HOLD;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (handshake) begin
                        src_data  <= sat(hs_data);
                        src_valid <= 1'b1;
                        state     <= ST_HOLD;
                        if (any_mode) begin
                            last_dir   <= hs_idx;
                            last_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (src_ready) begin
                        src_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
